// File: rtl/kf_bus_hold_arbiter.sv
// XT bus hold arbiter: hands the system bus between the 8088 and the DMA controller (HRQ/HLDA).
// Optional DMA tenure limit with sticky timeout flag when BUS_ARB_TIMEOUT_EN is defined.
module kf_bus_hold_arbiter #(
    parameter int unsigned DEADTIME_CYCLES = 2,
    parameter int unsigned MAX_HOLD_CYCLES = 1024
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       cpu_clock,
    input  logic [2:0] processor_status,
    input  logic       lock_n,
    input  logic       hold_request,
    output logic       hold_acknowledge,
    output logic       address_enable_n,
    output logic       dma_address_enable,
    output logic       cpu_wait_request,
    output logic [2:0] arbiter_state,
    output logic       hold_timeout
);

    // state   | meaning
    // CPU     | CPU owns the bus
    // SYNC    | HRQ seen, waiting for a passive, unlocked CPU cycle
    // RELEASE | no master, deadtime before handing to DMA
    // GRANT   | DMA owns the bus, HLDA asserted
    // RETURN  | no master, deadtime before handing back to CPU
    typedef enum logic [2:0] {
        ST_CPU     = 3'd0,
        ST_SYNC    = 3'd1,
        ST_RELEASE = 3'd2,
        ST_GRANT   = 3'd3,
        ST_RETURN  = 3'd4
    } state_t;

    localparam logic [3:0] DEAD_LOAD = 4'(DEADTIME_CYCLES - 1);

    if (DEADTIME_CYCLES < 1 || DEADTIME_CYCLES > 15 || MAX_HOLD_CYCLES < 1) begin : g_bad_param
        $error("kf_bus_hold_arbiter: parameter out of range");
    end

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       prev_cpu_clock_q;
    logic       posedge_evt;
    logic       hlda_q, aen_n_q, dma_aen_q, wait_q;
    logic       grant_allowed;
    logic       off_bus_d;

    assign posedge_evt = ~prev_cpu_clock_q & cpu_clock;

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int TW = $clog2(MAX_HOLD_CYCLES + 1);
    logic [TW-1:0] tenure_q, tenure_d;
    logic          timeout_q, timeout_d;
    logic          need_low_q, need_low_d;

    assign grant_allowed = ~need_low_q;
    assign hold_timeout  = timeout_q;
`else
    assign grant_allowed = 1'b1;
    assign hold_timeout  = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
`ifdef BUS_ARB_TIMEOUT_EN
        tenure_d   = tenure_q;
        timeout_d  = timeout_q;
        need_low_d = need_low_q;
`endif
        if (posedge_evt) begin
`ifdef BUS_ARB_TIMEOUT_EN
            if (!hold_request) need_low_d = 1'b0;
`endif
            case (state_q)
                ST_CPU: begin
                    if (hold_request && grant_allowed) state_d = ST_SYNC;
                end
                ST_SYNC: begin
                    if (!hold_request) begin
                        state_d = ST_CPU;
                    end else if (processor_status == 3'b111 && lock_n) begin
                        state_d = ST_RELEASE;
                        cnt_d   = DEAD_LOAD;
                    end
                end
                ST_RELEASE: begin
                    if (cnt_q == 4'd0) begin
                        state_d = ST_GRANT;
`ifdef BUS_ARB_TIMEOUT_EN
                        tenure_d = '0;
`endif
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                ST_GRANT: begin
                    if (!hold_request) begin
                        state_d = ST_RETURN;
                        cnt_d   = DEAD_LOAD;
                    end
`ifdef BUS_ARB_TIMEOUT_EN
                    // tenure limit forces the bus back even with HRQ still high
                    else if (tenure_q == TW'(MAX_HOLD_CYCLES - 1)) begin
                        state_d    = ST_RETURN;
                        cnt_d      = DEAD_LOAD;
                        timeout_d  = 1'b1;
                        need_low_d = 1'b1;
                    end else begin
                        tenure_d = tenure_q + 1'b1;
                    end
`endif
                end
                ST_RETURN: begin
                    if (cnt_q == 4'd0) state_d = ST_CPU;
                    else               cnt_d   = cnt_q - 4'd1;
                end
                default: state_d = ST_CPU;
            endcase
        end
    end

    assign off_bus_d = (state_d == ST_RELEASE) || (state_d == ST_GRANT) || (state_d == ST_RETURN);

    // outputs are flopped from next state so they move in step with state_q
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q          <= ST_CPU;
            cnt_q            <= 4'd0;
            prev_cpu_clock_q <= 1'b0;
            hlda_q           <= 1'b0;
            aen_n_q          <= 1'b0;
            dma_aen_q        <= 1'b0;
            wait_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            prev_cpu_clock_q <= cpu_clock;
            hlda_q           <= (state_d == ST_GRANT);
            aen_n_q          <= off_bus_d;
            dma_aen_q        <= ~off_bus_d;
            wait_q           <= off_bus_d;
        end
    end

`ifdef BUS_ARB_TIMEOUT_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tenure_q   <= '0;
            timeout_q  <= 1'b0;
            need_low_q <= 1'b0;
        end else begin
            tenure_q   <= tenure_d;
            timeout_q  <= timeout_d;
            need_low_q <= need_low_d;
        end
    end
`endif

    assign hold_acknowledge   = hlda_q;
    assign address_enable_n   = aen_n_q;
    assign dma_address_enable = dma_aen_q;
    assign cpu_wait_request   = wait_q;
    assign arbiter_state      = state_q;

endmodule

// File: tb/tb_kf_bus_hold_arbiter.sv
// Directed bench for kf_bus_hold_arbiter; timeout scenario runs only with BUS_ARB_TIMEOUT_EN.
module tb_kf_bus_hold_arbiter;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       cpu_clock = 1'b0;
    logic [2:0] processor_status = 3'b111;
    logic       lock_n = 1'b1;
    logic       hold_request = 1'b0;
    logic       hold_acknowledge, address_enable_n, dma_address_enable, cpu_wait_request;
    logic [2:0] arbiter_state;
    logic       hold_timeout;

    int errors = 0;
    int checks = 0;

    kf_bus_hold_arbiter #(.DEADTIME_CYCLES(2), .MAX_HOLD_CYCLES(8)) dut (
        .clock              (clock),
        .reset              (reset),
        .cpu_clock          (cpu_clock),
        .processor_status   (processor_status),
        .lock_n             (lock_n),
        .hold_request       (hold_request),
        .hold_acknowledge   (hold_acknowledge),
        .address_enable_n   (address_enable_n),
        .dma_address_enable (dma_address_enable),
        .cpu_wait_request   (cpu_wait_request),
        .arbiter_state      (arbiter_state),
        .hold_timeout       (hold_timeout)
    );

    always #5 clock = ~clock;

    // one cpu_clock period = 4 system clocks; returns on a negedge after the rising edge was seen
    task automatic tick();
        @(negedge clock) cpu_clock = 1'b1;
        @(negedge clock);
        @(negedge clock) cpu_clock = 1'b0;
        @(negedge clock);
    endtask

    task automatic go_grant();
        processor_status = 3'b111;
        lock_n = 1'b1;
        hold_request = 1'b1;
        repeat (4) tick();
    endtask

    task automatic go_cpu();
        hold_request = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        checks++; if (arbiter_state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", arbiter_state); end
        checks++; if (hold_acknowledge !== 1'b0) begin errors++; $display("FAIL reset_hlda: got %b expected 0", hold_acknowledge); end
        checks++; if (address_enable_n !== 1'b0) begin errors++; $display("FAIL reset_aen_n: got %b expected 0", address_enable_n); end
        checks++; if (dma_address_enable !== 1'b0) begin errors++; $display("FAIL reset_dma_aen: got %b expected 0", dma_address_enable); end
        checks++; if (cpu_wait_request !== 1'b0) begin errors++; $display("FAIL reset_wait: got %b expected 0", cpu_wait_request); end
        checks++; if (hold_timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b expected 0", hold_timeout); end
        reset = 1'b0;
        tick();
        checks++; if (dma_address_enable !== 1'b1) begin errors++; $display("FAIL idle_dma_aen: got %b expected 1", dma_address_enable); end
        checks++; if (arbiter_state !== 3'd0) begin errors++; $display("FAIL idle_state: got %0d expected 0", arbiter_state); end
    endtask

    task automatic test_idle_grant();
        processor_status = 3'b111; lock_n = 1'b1; hold_request = 1'b1;
        tick();
        checks++; if (arbiter_state !== 3'd1 || address_enable_n !== 1'b0) begin errors++; $display("FAIL grant_e1: got state %0d aen_n %b expected 1/0", arbiter_state, address_enable_n); end
        tick();
        checks++; if (arbiter_state !== 3'd2 || address_enable_n !== 1'b1) begin errors++; $display("FAIL grant_e2: got state %0d aen_n %b expected 2/1", arbiter_state, address_enable_n); end
        checks++; if (cpu_wait_request !== 1'b1 || dma_address_enable !== 1'b0 || hold_acknowledge !== 1'b0) begin errors++; $display("FAIL grant_e2_outs: got wait %b dma %b hlda %b expected 1/0/0", cpu_wait_request, dma_address_enable, hold_acknowledge); end
        tick();
        checks++; if (arbiter_state !== 3'd2 || hold_acknowledge !== 1'b0) begin errors++; $display("FAIL grant_e3: got state %0d hlda %b expected 2/0", arbiter_state, hold_acknowledge); end
        tick();
        checks++; if (arbiter_state !== 3'd3 || hold_acknowledge !== 1'b1) begin errors++; $display("FAIL grant_e4: got state %0d hlda %b expected 3/1", arbiter_state, hold_acknowledge); end
    endtask

    task automatic test_return();
        hold_request = 1'b0;
        tick();
        checks++; if (arbiter_state !== 3'd4 || hold_acknowledge !== 1'b0 || address_enable_n !== 1'b1) begin errors++; $display("FAIL ret_e1: got state %0d hlda %b aen_n %b expected 4/0/1", arbiter_state, hold_acknowledge, address_enable_n); end
        tick();
        checks++; if (address_enable_n !== 1'b1 || cpu_wait_request !== 1'b1) begin errors++; $display("FAIL ret_e2: got aen_n %b wait %b expected 1/1", address_enable_n, cpu_wait_request); end
        tick();
        checks++; if (arbiter_state !== 3'd0 || address_enable_n !== 1'b0 || cpu_wait_request !== 1'b0 || dma_address_enable !== 1'b1) begin errors++; $display("FAIL ret_e3: got state %0d aen_n %b wait %b dma %b expected 0/0/0/1", arbiter_state, address_enable_n, cpu_wait_request, dma_address_enable); end
    endtask

    task automatic test_busy_cpu();
        processor_status = 3'b101; hold_request = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (arbiter_state !== 3'd1 || address_enable_n !== 1'b0) begin errors++; $display("FAIL busy_hold[%0d]: got state %0d aen_n %b expected 1/0", i, arbiter_state, address_enable_n); end
        end
        processor_status = 3'b111;
        tick();
        checks++; if (arbiter_state !== 3'd2) begin errors++; $display("FAIL busy_release: got %0d expected 2", arbiter_state); end
        // HRQ dropping during RELEASE must not abort
        hold_request = 1'b0;
        tick();
        tick();
        checks++; if (arbiter_state !== 3'd3 || hold_acknowledge !== 1'b1) begin errors++; $display("FAIL release_no_abort: got state %0d hlda %b expected 3/1", arbiter_state, hold_acknowledge); end
        tick();
        checks++; if (arbiter_state !== 3'd4) begin errors++; $display("FAIL release_then_return: got %0d expected 4", arbiter_state); end
        tick(); tick();
    endtask

    task automatic test_lock();
        processor_status = 3'b111; lock_n = 1'b0; hold_request = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++; if (arbiter_state !== 3'd1 || address_enable_n !== 1'b0 || hold_acknowledge !== 1'b0) begin errors++; $display("FAIL lock_hold[%0d]: got state %0d aen_n %b hlda %b expected 1/0/0", i, arbiter_state, address_enable_n, hold_acknowledge); end
        end
        lock_n = 1'b1;
        tick();
        checks++; if (arbiter_state !== 3'd2 || address_enable_n !== 1'b1) begin errors++; $display("FAIL lock_release: got state %0d aen_n %b expected 2/1", arbiter_state, address_enable_n); end
        tick(); tick();
        checks++; if (hold_acknowledge !== 1'b1) begin errors++; $display("FAIL lock_grant: got %b expected 1", hold_acknowledge); end
        go_cpu();
    endtask

    task automatic test_return_ignore();
        go_grant();
        hold_request = 1'b0;
        tick();
        hold_request = 1'b1;
        tick();
        checks++; if (arbiter_state !== 3'd4) begin errors++; $display("FAIL ret_ignore_e2: got %0d expected 4", arbiter_state); end
        tick();
        checks++; if (arbiter_state !== 3'd0 || address_enable_n !== 1'b0) begin errors++; $display("FAIL ret_ignore_cpu: got state %0d aen_n %b expected 0/0", arbiter_state, address_enable_n); end
        tick();
        checks++; if (arbiter_state !== 3'd1) begin errors++; $display("FAIL ret_ignore_sync: got %0d expected 1", arbiter_state); end
        go_cpu();
    endtask

    task automatic test_edge_only();
        hold_request = 1'b1; processor_status = 3'b111; lock_n = 1'b1;
        repeat (6) @(negedge clock);
        checks++; if (arbiter_state !== 3'd0) begin errors++; $display("FAIL no_edge: got %0d expected 0", arbiter_state); end
        cpu_clock = 1'b1;
        repeat (6) @(negedge clock);
        checks++; if (arbiter_state !== 3'd1) begin errors++; $display("FAIL level_high: got %0d expected 1", arbiter_state); end
        cpu_clock = 1'b0;
        @(negedge clock);
        go_cpu();
    endtask

    task automatic test_abort();
        processor_status = 3'b101; hold_request = 1'b1;
        tick();
        checks++; if (arbiter_state !== 3'd1) begin errors++; $display("FAIL abort_sync: got %0d expected 1", arbiter_state); end
        hold_request = 1'b0;
        tick();
        checks++; if (arbiter_state !== 3'd0 || address_enable_n !== 1'b0) begin errors++; $display("FAIL abort_cpu: got state %0d aen_n %b expected 0/0", arbiter_state, address_enable_n); end
        processor_status = 3'b111;
    endtask

    task automatic test_reset_mid();
        go_grant();
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        checks++; if (hold_acknowledge !== 1'b0 || address_enable_n !== 1'b0 || cpu_wait_request !== 1'b0 || dma_address_enable !== 1'b0 || arbiter_state !== 3'd0) begin errors++; $display("FAIL reset_mid: got hlda %b aen_n %b wait %b dma %b state %0d expected all 0", hold_acknowledge, address_enable_n, cpu_wait_request, dma_address_enable, arbiter_state); end
        hold_request = 1'b0;
        @(negedge clock) reset = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        go_grant();
`ifdef BUS_ARB_TIMEOUT_EN
        for (int i = 0; i < 7; i++) begin
            tick();
            checks++; if (hold_acknowledge !== 1'b1) begin errors++; $display("FAIL tmo_tenure[%0d]: got %b expected 1", i, hold_acknowledge); end
        end
        tick();
        checks++; if (arbiter_state !== 3'd4 || hold_acknowledge !== 1'b0 || hold_timeout !== 1'b1) begin errors++; $display("FAIL tmo_fire: got state %0d hlda %b tmo %b expected 4/0/1", arbiter_state, hold_acknowledge, hold_timeout); end
        tick(); tick(); tick();
        checks++; if (arbiter_state !== 3'd0) begin errors++; $display("FAIL tmo_no_regrant: got %0d expected 0", arbiter_state); end
        hold_request = 1'b0;
        tick();
        hold_request = 1'b1;
        tick();
        checks++; if (arbiter_state !== 3'd1 || hold_timeout !== 1'b1) begin errors++; $display("FAIL tmo_rearm: got state %0d tmo %b expected 1/1", arbiter_state, hold_timeout); end
`else
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++; if (hold_acknowledge !== 1'b1 || hold_timeout !== 1'b0) begin errors++; $display("FAIL long_grant[%0d]: got hlda %b tmo %b expected 1/0", i, hold_acknowledge, hold_timeout); end
        end
`endif
        go_cpu();
    endtask

    initial begin
        test_reset();
        test_idle_grant();
        test_return();
        test_busy_cpu();
        test_lock();
        test_return_ignore();
        test_edge_only();
        test_abort();
        test_timeout();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
